// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline constants and the fetch FSM state type.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Single-entry {instr, pc} holding register that catches a response when
// decode is stalled; flush has priority over load, load over unload.
module fetch_skid_buffer
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            unload_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            full_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);

  logic            full_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (load_i) begin
      full_q  <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (unload_i) begin
      full_q  <= 1'b0;
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, keeps one request outstanding to
// instruction memory and feeds the IF/ID register, honouring stalls and redirects.
//
//   state | meaning
//   REQ   | request driven, waiting for grant
//   WAIT  | one request outstanding, waiting for rvalid
//   HOLD  | response parked in skid buffer, decode stalled
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc4_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         discard_q, discard_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  id_pc_q, id_pc_d;
  logic [31:0]  id_pc4_q, id_pc4_d;

  logic        sink_free;
  logic        handshake;
  logic        take_word;
  logic        skid_load, skid_unload, skid_flush;
  logic        skid_full;
  logic [31:0] skid_instr, skid_pc;

  assign sink_free = !valid_q || !stall_i;

  // A new request may go out of WAIT only in the cycle its predecessor returns.
  assign imem_req_o = !rst && !redirect_i &&
                      ((state_q == REQ) ||
                       ((state_q == WAIT) && imem_rvalid_i && !discard_q && sink_free));
  assign imem_addr_o = pc_q;
  assign handshake   = imem_req_o && imem_gnt_i;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    discard_d   = discard_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    id_pc_d     = id_pc_q;
    id_pc4_d    = id_pc4_q;
    take_word   = 1'b0;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_flush  = 1'b0;

    if (redirect_i) begin
      pc_d       = word_align(redirect_pc_i);
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      skid_flush = 1'b1;
      discard_d  = 1'b0;
      state_d    = REQ;
      // The in-flight word must still be swallowed when it eventually arrives.
      if ((state_q == WAIT) && !imem_rvalid_i) begin
        discard_d = 1'b1;
        state_d   = WAIT;
      end
    end else begin
      if (handshake) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + 32'd4;
      end

      case (state_q)
        REQ: begin
          if (handshake) state_d = WAIT;
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = REQ;
            end else if (sink_free) begin
              take_word = 1'b1;
              state_d   = handshake ? WAIT : REQ;
            end else begin
              skid_load = 1'b1;
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          if (sink_free) begin
            skid_unload = 1'b1;
            state_d     = REQ;
          end
        end
        default: state_d = REQ;
      endcase

      if (take_word) begin
        valid_d  = 1'b1;
        instr_d  = imem_rdata_i;
        id_pc_d  = req_pc_q;
        id_pc4_d = req_pc_q + 32'd4;
      end else if (skid_unload) begin
        valid_d  = 1'b1;
        instr_d  = skid_instr;
        id_pc_d  = skid_pc;
        id_pc4_d = skid_pc + 32'd4;
      end else if (sink_free && !stall_i) begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      req_pc_q  <= '0;
      discard_q <= 1'b0;
      valid_q   <= 1'b0;
      instr_q   <= NOP_INSTR;
      id_pc_q   <= '0;
      id_pc4_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      discard_q <= discard_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      id_pc_q   <= id_pc_d;
      id_pc4_q  <= id_pc4_d;
    end
  end

  fetch_skid_buffer u_skid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .flush_i  (skid_flush),
    .instr_i  (imem_rdata_i),
    .pc_i     (req_pc_q),
    .full_o   (skid_full),
    .instr_o  (skid_instr),
    .pc_o     (skid_pc)
  );

  assign if_id_valid_o = valid_q;
  assign if_id_instr_o = instr_q;
  assign if_id_pc_o    = id_pc_q;
  assign if_id_pc4_o   = id_pc4_q;

  // Skid occupancy is implied by the HOLD state; kept visible for debug probes.
  logic unused_skid_full;
  assign unused_skid_full = skid_full;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised fetch-stage bench: a memory model plus program-order scoreboard
// predicts every instruction decode should accept.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        if_id_valid_o;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc4_o;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_id_valid_o (if_id_valid_o),
    .if_id_instr_o (if_id_instr_o),
    .if_id_pc_o    (if_id_pc_o),
    .if_id_pc4_o   (if_id_pc4_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int consumed = 0;

  // knobs
  int p_stall = 0, p_redir = 0, p_gnt = 100, d_min = 1, d_max = 1;
  bit rst_req = 1'b1, f_stall = 1'b0, f_redir = 1'b0;
  logic [31:0] f_target = '0;
  bit zw_mode = 1'b0, lat_armed = 1'b0;

  // memory + fetch-address model
  bit          mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  logic [31:0] next_addr = RESET_PC;
  int          since_rst = -1;
  bit          prev_ungranted = 1'b0;
  logic [31:0] prev_req_addr = '0;
  bit          saw_top = 1'b0, saw_wrap = 1'b0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a >> 2) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    logic hs;
    @(negedge clk);
    rst     = rst_req;
    stall_i = f_stall ? 1'b1 : ($urandom_range(0, 99) < p_stall);
    if (f_redir) begin
      redirect_i    = 1'b1;
      redirect_pc_i = f_target;
    end else begin
      redirect_i    = ($urandom_range(0, 999) < p_redir);
      redirect_pc_i = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFE0 | $urandom_range(0, 31))
                                                  : 32'($urandom_range(0, 4095));
    end
    imem_gnt_i = ($urandom_range(0, 99) < p_gnt);
    if (mem_pend && mem_cnt == 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = word_at(mem_addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
      if (mem_pend) mem_cnt--;
    end
    #1;
    if (rst) begin
      chk("req_in_reset", {31'b0, imem_req_o}, 32'd0);
      mem_pend = 1'b0;
      exp_q.delete();
      next_addr = RESET_PC;
      since_rst = -1;
      prev_ungranted = 1'b0;
    end else begin
      since_rst++;
      if (redirect_i)
        chk("req_in_redirect", {31'b0, imem_req_o}, 32'd0);
      else if (prev_ungranted) begin
        chk("req_held", {31'b0, imem_req_o}, 32'd1);
        chk("addr_held", imem_addr_o, prev_req_addr);
      end
      if (imem_req_o && mem_pend && !imem_rvalid_i)
        chk("single_outstanding", 32'd1, 32'd0);
      hs = imem_req_o && imem_gnt_i;
      if (hs) begin
        chk("fetch_addr", imem_addr_o, next_addr);
        exp_q.push_back('{pc: next_addr, instr: word_at(next_addr)});
        if (next_addr == 32'hFFFF_FFFC) saw_top = 1'b1;
        else if (saw_top && next_addr == 32'h0) saw_wrap = 1'b1;
        mem_addr  = next_addr;
        next_addr = next_addr + 32'd4;
      end
      if (redirect_i) begin
        exp_q.delete();
        next_addr = {redirect_pc_i[31:2], 2'b00};
      end
      prev_ungranted = imem_req_o && !imem_gnt_i;
      prev_req_addr  = imem_addr_o;
      if (imem_rvalid_i) mem_pend = 1'b0;
      if (hs) begin
        mem_pend = 1'b1;
        mem_cnt  = $urandom_range(d_min, d_max) - 1;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // monitor: checks IF/ID every cycle and pops the scoreboard on acceptance
  initial begin : monitor
    bit          p_rst = 1'b1, p_redir = 1'b0, p_stall = 1'b0, p_valid = 1'b0;
    logic [31:0] p_instr = '0, p_pc = '0, p_pc4 = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      #2;
      if (p_rst) begin
        chk("rst_valid", {31'b0, if_id_valid_o}, 32'd0);
        chk("rst_instr", if_id_instr_o, NOP);
        chk("rst_pc", if_id_pc_o, 32'd0);
        chk("rst_pc4", if_id_pc4_o, 32'd0);
      end else begin
        if (!if_id_valid_o) chk("bubble_is_nop", if_id_instr_o, NOP);
        if (p_redir) chk("flush_after_redirect", {31'b0, if_id_valid_o}, 32'd0);
        else if (p_valid && p_stall) begin
          chk("stall_hold_valid", {31'b0, if_id_valid_o}, 32'd1);
          chk("stall_hold_instr", if_id_instr_o, p_instr);
          chk("stall_hold_pc", if_id_pc_o, p_pc);
          chk("stall_hold_pc4", if_id_pc4_o, p_pc4);
        end
      end
      if (!rst && if_id_valid_o && !stall_i && !redirect_i) begin
        if (exp_q.size() == 0) chk("unexpected_instr_pc", if_id_pc_o, 32'hXXXX_XXXX);
        else begin
          e = exp_q.pop_front();
          chk("id_pc", if_id_pc_o, e.pc);
          chk("id_instr", if_id_instr_o, e.instr);
          chk("id_pc4", if_id_pc4_o, e.pc + 32'd4);
          consumed++;
        end
      end
      if (lat_armed && !rst && (if_id_valid_o || since_rst > 2)) begin
        chk("first_fetch_latency", 32'(since_rst), 32'd2);
        lat_armed = 1'b0;
      end
      if (zw_mode && !rst && since_rst >= 2)
        chk("zero_wait_throughput", {31'b0, if_id_valid_o}, 32'd1);
      p_rst = rst; p_redir = redirect_i; p_stall = stall_i; p_valid = if_id_valid_o;
      p_instr = if_id_instr_o; p_pc = if_id_pc_o; p_pc4 = if_id_pc4_o;
    end
  end

  task automatic set_mode(input int st, input int rd, input int gn, input int dmin, input int dmax);
    p_stall = st; p_redir = rd; p_gnt = gn; d_min = dmin; d_max = dmax;
  endtask

  initial begin
    set_mode(0, 0, 100, 1, 1);
    rst_req = 1'b1;
    run(3);
    zw_mode = 1'b1; lat_armed = 1'b1; rst_req = 1'b0;
    run(20);
    zw_mode = 1'b0;

    set_mode(50, 0, 100, 1, 1);  run(200);
    set_mode(0, 0, 30, 1, 3);    run(200);
    set_mode(30, 60, 70, 1, 3);  run(1500);

    // redirect colliding with stall and a returning word
    set_mode(0, 0, 100, 1, 1);   run(6);
    f_stall = 1'b1; f_redir = 1'b1; f_target = 32'h0000_0100;
    cycle();
    chk("redir_rvalid_seen", {31'b0, imem_rvalid_i}, 32'd1);
    f_stall = 1'b0; f_redir = 1'b0;
    run(10);

    // misaligned target at the top of the address space
    f_redir = 1'b1; f_target = 32'hFFFF_FFFE;
    cycle();
    f_redir = 1'b0;
    run(8);
    chk("wrap_top_fetched", {31'b0, saw_top}, 32'd1);
    chk("wrap_zero_fetched", {31'b0, saw_wrap}, 32'd1);

    // mid-operation reset
    set_mode(30, 40, 70, 1, 3);  run(30);
    rst_req = 1'b1; run(2);
    rst_req = 1'b0; run(500);

    chk("progress", {31'b0, (consumed >= 200)}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline; sits directly upstream of the decode/control unit.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Delivers fetched words plus PC tags through the IF/ID pipeline register.
- Honours decode stalls and EX-stage redirects (taken branch, JAL, JALR).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble word (addi x0,x0,0) placed in IF/ID when invalid.

Ports:
clk  in  1  system clock; one clock, all state on rising edge
rst  in  1  reset; synchronous, active-high
stall_i  in  1  decode cannot accept; hold IF/ID
redirect_i  in  1  EX resolved taken branch/jump
redirect_pc_i  in  32  redirect target
imem_req_o  out  1  fetch request valid
imem_addr_o  out  32  fetch word address
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response valid (>=1 cycle after grant)
imem_rdata_i  in  32  fetched instruction
if_id_valid_o  out  1  IF/ID holds a real instruction
if_id_instr_o  out  32  instruction to decode (NOP_INSTR when invalid)
if_id_pc_o  out  32  PC of that instruction
if_id_pc4_o  out  32  PC+4 (for JAL/JALR link)

Behaviour:
- Reset values: pc=RESET_PC, req_pc=0, state=REQ, discard=0, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc4=0, skid registers=0. imem_req_o is 0 while rst=1.
- A reset asserted mid-operation abandons any outstanding request. An rvalid arriving after reset is ignored, because state is REQ.
- Definitions:
  - sink_free = !if_id_valid || !stall_i.
  - A handshake completes when imem_req_o && imem_gnt_i.
  - At most one request is outstanding at any time.
- imem_addr_o = pc.
- imem_req_o = !rst && !redirect_i && ((state==REQ) || (state==WAIT && imem_rvalid_i && !discard && sink_free)).
- On handshake: req_pc<=pc; pc<=pc+4, mod 2^32 so 32'hFFFF_FFFC wraps to 0; state<=WAIT.
- States:
  - REQ: drive request. Stay until granted.
  - WAIT: request outstanding. On rvalid with discard=1: drop the word, discard<=0, go REQ. On rvalid with sink_free: load IF/ID {valid=1, instr=rdata, pc=req_pc, pc4=req_pc+4}; stay WAIT if reissued and granted, else go REQ. On rvalid with !sink_free: capture into skid, go HOLD.
  - HOLD: skid full, no request issued. When sink_free: move skid to IF/ID, go REQ.
- IF/ID update:
  - If no new word and sink_free with !stall_i: if_id_valid<=0, instr<=NOP_INSTR.
  - If stall_i && if_id_valid: all IF/ID outputs hold.
- Redirect (priority over stall and over every response):
  - pc<={redirect_pc_i[31:2],2'b00}; misaligned low bits are dropped silently.
  - if_id_valid<=0, if_id_instr<=NOP_INSTR, skid emptied.
  - From WAIT without rvalid: discard<=1, stay WAIT.
  - From WAIT with rvalid that same cycle: drop the word, go REQ.
  - From REQ or HOLD: go REQ.
  - No request is issued in the redirect cycle.
- Latency and throughput:
  - With a zero-wait memory (gnt=1, rvalid one cycle later), the first instruction reaches IF/ID 2 cycles after rst falls.
  - Sustained rate is 1 instruction/cycle.
  - After a redirect, the target reaches IF/ID 3 cycles later.

Decomposition:
- Shared package riscv_pkg: NOP_INSTR, RESET_PC default, fetch_state_t enum {REQ, WAIT, HOLD}, XLEN=32.
- One natural sub-module: fetch_skid_buffer, a single-entry {instr, pc} register with load/unload/flush. The rest stays in fetch_stage.

Test Plan:
- Reset release, memory gnt=1, 1-cycle rvalid, mem[i]=i → IF/ID shows pc 0,4,8,… with instr=word, valid every cycle from cycle 2; pc4=pc+4.
- stall_i held 3 cycles while the response for pc=0x10 is in flight → pc 0x0C holds in IF/ID; 0x10 goes to skid (HOLD, imem_req_o=0); on release 0x10 then 0x14 appear with none lost or duplicated.
- redirect_i with target 0x100 while WAIT for 0x20 and rvalid arriving 2 cycles later → word for 0x20 never reaches IF/ID; next valid instr has pc=0x100.
- redirect_i and imem_rvalid_i in the same cycle as stall_i=1 → IF/ID flushed to NOP_INSTR with valid=0; no request that cycle; next fetch address is target.
- imem_gnt_i low for 4 cycles → imem_addr_o stable, pc not incremented, single request outstanding.
- redirect_pc_i=0xFFFF_FFFE → fetch at 0xFFFF_FFFC, then wraps to 0x0000_0000.
